// File: rtl/fp_alu_pkg.sv
// Shared types and constants for the FP ALU arbiter slice.
// No logic of its own. It provides the state encoding, op selects, flag bit positions
// and IEEE-754 single-precision exponent codes.
package fp_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  // rsp_flags layout is {nan, ovf, unf}
  localparam int FLAG_NAN = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;
  localparam logic [7:0] EXP_ZERO     = 8'h00;

  // Classify a single-precision value. An all-ones exponent with a zero fraction
  // is reported as overflow, because infinity is what the ALU produces on overflow.
  function automatic logic [2:0] fp_flags(input logic [31:0] v);
    logic [2:0] f;
    f = 3'b000;
    f[FLAG_NAN] = (v[30:23] == EXP_ALL_ONES) && (v[22:0] != 23'd0);
    f[FLAG_OVF] = (v[30:23] == EXP_ALL_ONES) && (v[22:0] == 23'd0);
    f[FLAG_UNF] = (v[30:23] == EXP_ZERO);
    return f;
  endfunction

endpackage

// File: rtl/fp_alu_arbiter_rr_arbiter.sv
// Round-robin arbiter. It turns a request vector and a priority pointer into a one-hot grant.
// Latency: purely combinational, zero cycles.
// Backpressure: none. The caller decides when a grant is consumed and when the pointer advances.
// Ports: req (request vector), ptr (highest-priority index), gnt (one-hot grant),
//        gnt_idx (encoded grant index), gnt_vld (any grant given).
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);

  // Walk the requesters starting at ptr and wrap past NREQ-1 back to 0.
  // The first requester found wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_vld && req[idx]) begin
        gnt_vld      = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fp_alu_arbiter.sv
// Shares one combinational FP ALU (sel 0 = add, 1 = mul) among NREQ requesters.
// It grants in round-robin order and keeps one op in flight.
// Latency: rsp_valid rises ALU_LAT cycles after the accept edge.
// Sustained throughput is at most one op every ALU_LAT+2 cycles.
// Backpressure: req_ready is low except in IDLE. While rsp_ready is low,
// rsp_data, rsp_id and rsp_flags are held.
// Ports: clk/rst_n (synchronous, active low); req_valid/req_ready/req_in1/req_in2/req_sel
//        are per-requester and packed at [i*XLEN +: XLEN]; alu_in1/alu_in2/alu_sel are the
//        registered ALU operands; alu_result is the ALU output; rsp_valid/rsp_ready/rsp_data/
//        rsp_id/rsp_flags carry the response.
// Optional: define FP_ALU_ARB_FLAGS_EN to compute {nan, ovf, unf} on rsp_flags.
//           If it is undefined, the flags are tied to zero.
module fp_alu_arbiter
  import fp_alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREQ    = 2,
  parameter int ALU_LAT = 2,
  parameter int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_in1,
  input  logic [NREQ*XLEN-1:0] req_in2,
  input  logic [NREQ-1:0]      req_sel,
  output logic [XLEN-1:0]      alu_in1,
  output logic [XLEN-1:0]      alu_in2,
  output logic                 alu_sel,
  input  logic [XLEN-1:0]      alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_data,
  output logic [IW-1:0]        rsp_id,
  output logic [2:0]           rsp_flags
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_vld;
  logic              accept;
  logic              capture;
  logic              rsp_done;
  logic [XLEN-1:0]   sel_in1;
  logic [XLEN-1:0]   sel_in2;
  logic              sel_op;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Mux out the winner's operands. The loop index is constant, so the slices are static.
  always_comb begin
    sel_in1 = '0;
    sel_in2 = '0;
    sel_op  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_in1 = req_in1[i*XLEN +: XLEN];
        sel_in2 = req_in2[i*XLEN +: XLEN];
        sel_op  = req_sel[i];
      end
    end
  end

  // Next-state logic and handshake strobes.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    rsp_done  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = gnt;
        if (gnt_vld) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_sel   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Operands stay in these registers after completion, so the ALU inputs do not toggle while idle.
        alu_in1 <= sel_in1;
        alu_in2 <= sel_in2;
        alu_sel <= sel_op;
        rsp_id  <= gnt_idx;
        cnt_q   <= CW'(ALU_LAT - 1);
        ptr_q   <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
      end else if (state_q == EXEC && cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (capture) begin
        rsp_data  <= alu_result;
        rsp_valid <= 1'b1;
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef FP_ALU_ARB_FLAGS_EN
  logic [2:0] flags_q;

  // The flags are sampled on the same edge as rsp_data, so they always describe the word that is presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else if (capture) begin
      flags_q <= fp_flags(alu_result[31:0]);
    end
  end

  assign rsp_flags = flags_q;
`else
  assign rsp_flags = 3'b000;
`endif

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Directed bench for fp_alu_arbiter with NREQ=2 and ALU_LAT=2.
// A small behavioural ALU supplies known IEEE-754 results.
// Expected responses are queued on accept and compared when the response handshake completes.
module tb_fp_alu_arbiter;
  import fp_alu_pkg::*;

  localparam int XLEN    = 32;
  localparam int NREQ    = 2;
  localparam int ALU_LAT = 2;
  localparam int IW      = 1;
`ifdef FP_ALU_ARB_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_in1;
  logic [NREQ*XLEN-1:0] req_in2;
  logic [NREQ-1:0]      req_sel;
  logic [XLEN-1:0]      alu_in1;
  logic [XLEN-1:0]      alu_in2;
  logic                 alu_sel;
  logic [XLEN-1:0]      alu_result;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [XLEN-1:0]      rsp_data;
  logic [IW-1:0]        rsp_id;
  logic [2:0]           rsp_flags;

  always #5 clk = ~clk;

  fp_alu_arbiter #(
    .XLEN    (XLEN),
    .NREQ    (NREQ),
    .ALU_LAT (ALU_LAT),
    .IW      (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_in1    (req_in1),
    .req_in2    (req_in2),
    .req_sel    (req_sel),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_flags  (rsp_flags)
  );

  // Behavioural ALU that knows only the operand pairs this bench uses.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (s == OP_MUL && a == 32'h3F800000 && b == 32'h40000000) return 32'h40000000;
    if (s == OP_MUL && a == 32'h41200000 && b == 32'hC1A00000) return 32'hC3480000;
    if (s == OP_MUL && a == 32'h7F7FFFFF && b == 32'h40000000) return 32'h7F800000;
    if (s == OP_MUL && a == 32'h7F800000 && b == 32'h7FC00000) return 32'h7FC00000;
    if (s == OP_MUL && a == 32'h00800000 && b == 32'h00800000) return 32'h00000000;
    if (s == OP_ADD && a == 32'h3F800000 && b == 32'hBF800000) return 32'h00000000;
    if (s == OP_ADD && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    return 32'hDEADBEEF ^ a;
  endfunction

  always_comb alu_result = alu_model(alu_in1, alu_in2, alu_sel);

  typedef struct packed {
    logic [31:0]   data;
    logic [IW-1:0] id;
    logic [2:0]    flags;
  } exp_t;

  exp_t        sb[$];
  int          gnt_log[$];
  int          acc_cnt[NREQ];
  logic [31:0] exp_data[NREQ];
  logic [2:0]  exp_flags[NREQ];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] fl(input logic [2:0] f);
    return FLAGS_ON ? f : 3'b000;
  endfunction

  // Samples the DUT mid-cycle. A handshake that is visible here completes on the next posedge.
  task automatic observe();
    exp_t e;
    check("req_ready_onehot", {31'd0, ($countones(req_ready) <= 1)}, 32'd1);
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.data  = exp_data[i];
        e.id    = IW'(i);
        e.flags = exp_flags[i];
        sb.push_back(e);
        gnt_log.push_back(i);
        acc_cnt[i]++;
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL rsp_unexpected observed=%h expected=no_response", rsp_data);
      end else begin
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
        check("rsp_flags", {29'd0, rsp_flags}, {29'd0, e.flags});
      end
    end
  endtask

  task automatic tick();
    #1 observe();
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] r, input logic [2:0] f);
    req_in1[i*XLEN +: XLEN] = a;
    req_in2[i*XLEN +: XLEN] = b;
    req_sel[i]              = s;
    exp_data[i]             = r;
    exp_flags[i]            = fl(f);
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] r, input logic [2:0] f);
    int a0;
    int n;
    set_op(i, a, b, s, r, f);
    req_valid[i] = 1'b1;
    a0 = acc_cnt[i];
    n  = 0;
    while (acc_cnt[i] == a0 && n < 50) begin
      tick();
      n++;
    end
    check("accept", acc_cnt[i] - a0, 1);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    int cyc;
    int hi;
    int a1;
    rst_n     = 1'b0;
    req_valid = '0;
    req_in1   = '0;
    req_in2   = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      acc_cnt[i]   = 0;
      exp_data[i]  = '0;
      exp_flags[i] = '0;
    end
    @(negedge clk);
    #1;
    tick();
    tick();

    // Reset state
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("rst_rsp_flags", {29'd0, rsp_flags}, 32'd0);
    check("rst_alu_in1", alu_in1, 32'd0);
    check("rst_alu_in2", alu_in2, 32'd0);
    check("rst_alu_sel", {31'd0, alu_sel}, 32'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    tick();

    // Single multiply from requester 0: check operand registers and latency
    issue(0, 32'h3F800000, 32'h40000000, OP_MUL, 32'h40000000, 3'b000);
    check("alu_in1", alu_in1, 32'h3F800000);
    check("alu_in2", alu_in2, 32'h40000000);
    check("alu_sel", {31'd0, alu_sel}, 32'd1);
    wait_rsp(cyc);
    check("latency", cyc, ALU_LAT);
    tick();

    // Requester 1 alone; the pointer goes back to 0
    issue(1, 32'h41200000, 32'hC1A00000, OP_MUL, 32'hC3480000, 3'b000);
    wait_rsp(cyc);
    tick();

    // Contention: both requesters keep valid asserted, so grants must alternate
    gnt_log.delete();
    set_op(0, 32'h3F800000, 32'h40000000, OP_MUL, 32'h40000000, 3'b000);
    set_op(1, 32'h41200000, 32'hC1A00000, OP_MUL, 32'hC3480000, 3'b000);
    req_valid = 2'b11;
    cyc = 0;
    while (gnt_log.size() < 4 && cyc < 100) begin
      tick();
      cyc++;
    end
    req_valid = 2'b00;
    check("contention_count", gnt_log.size(), 4);
    for (int k = 0; k < gnt_log.size() && k < 4; k++) check("contention_order", gnt_log[k], k % 2);
    wait_rsp(cyc);
    tick();

    // Backpressure: hold the response for 5 cycles while requester 1 waits
    rsp_ready = 1'b0;
    issue(0, 32'h3F800000, 32'h3F800000, OP_ADD, 32'h40000000, 3'b000);
    set_op(1, 32'h41200000, 32'hC1A00000, OP_MUL, 32'hC3480000, 3'b000);
    req_valid[1] = 1'b1;
    a1 = acc_cnt[1];
    wait_rsp(cyc);
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_data", rsp_data, 32'h40000000);
      check("bp_rsp_id", {31'd0, rsp_id}, 32'd0);
      check("bp_req_ready", {30'd0, req_ready}, 32'd0);
      tick();
    end
    check("bp_no_accept", acc_cnt[1] - a1, 0);
    rsp_ready = 1'b1;
    tick();
    tick();
    check("bp_accept_after", acc_cnt[1] - a1, 1);
    req_valid[1] = 1'b0;
    wait_rsp(cyc);
    tick();

    // Flag vectors and the add path
    issue(0, 32'h7F7FFFFF, 32'h40000000, OP_MUL, 32'h7F800000, 3'b010);
    wait_rsp(cyc);
    tick();
    issue(0, 32'h7F800000, 32'h7FC00000, OP_MUL, 32'h7FC00000, 3'b100);
    wait_rsp(cyc);
    tick();
    issue(0, 32'h00800000, 32'h00800000, OP_MUL, 32'h00000000, 3'b001);
    wait_rsp(cyc);
    tick();
    issue(1, 32'h3F800000, 32'hBF800000, OP_ADD, 32'h00000000, 3'b001);
    wait_rsp(cyc);
    tick();

    // Reset during EXEC: the op is dropped and the pointer goes back to 0
    issue(0, 32'h3F800000, 32'h40000000, OP_MUL, 32'h40000000, 3'b000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_exec_sb", sb.size(), 1);
    sb.delete();
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) hi++;
      tick();
    end
    check("rst_exec_no_rsp", hi, 0);
    check("rst_exec_alu_in1", alu_in1, 32'd0);
    gnt_log.delete();
    set_op(0, 32'h3F800000, 32'h40000000, OP_MUL, 32'h40000000, 3'b000);
    set_op(1, 32'h41200000, 32'hC1A00000, OP_MUL, 32'hC3480000, 3'b000);
    req_valid = 2'b11;
    tick();
    req_valid = 2'b00;
    check("rst_exec_grant_cnt", gnt_log.size(), 1);
    if (gnt_log.size() > 0) check("rst_exec_first_grant", gnt_log[0], 0);
    wait_rsp(cyc);
    tick();
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
